// File: rtl/if_id_skid_latch.sv
// IF/ID pipeline latch with a valid/ready handshake and a two-entry skid buffer.
// A flush (branch taken or jump) squashes every buffered entry and is counted when it discards work.
module if_id_skid_latch #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 11,
    parameter int                 PC_ADJ    = 1,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0,
    parameter int                 CNT_W     = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               enable,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instruc_in,
    input  logic [PC_W-1:0]    pc_plus_1_in,
    input  logic               branch_taken,
    input  logic               jump_sel,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] instruc_out,
    output logic [PC_W-1:0]    pc_out,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   flush_cnt,
    output logic [1:0]         fsm_state
);

    // Handshake: a beat moves on a rising edge only when valid and ready are both
    // high and enable is high; ready never depends on valid from the same side.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [INSTR_W-1:0] main_instr;
    logic [INSTR_W-1:0] main_instr_nxt;
    logic [PC_W-1:0]    main_pc;
    logic [PC_W-1:0]    main_pc_nxt;
    logic [INSTR_W-1:0] skid_instr;
    logic [INSTR_W-1:0] skid_instr_nxt;
    logic [PC_W-1:0]    skid_pc;
    logic [PC_W-1:0]    skid_pc_nxt;
    logic               flush;
    logic               acc;
    logic               cons;
    logic [PC_W-1:0]    pc_adj;

    assign flush     = branch_taken | jump_sel;
    assign in_ready  = (state != ST_FULL) & ~flush & ~reset;
    assign out_valid = (state != ST_EMPTY);
    assign acc       = in_valid & in_ready & enable;
    assign cons      = out_valid & out_ready & enable;
    assign pc_adj    = pc_plus_1_in - PC_W'(PC_ADJ);

    assign instruc_out = main_instr;
    assign pc_out      = main_pc;
    assign occupancy   = state;
    assign fsm_state   = state;

    always_comb begin
        state_nxt      = state;
        main_instr_nxt = main_instr;
        main_pc_nxt    = main_pc;
        skid_instr_nxt = skid_instr;
        skid_pc_nxt    = skid_pc;
        case (state)
            ST_EMPTY: begin
                if (acc) begin
                    state_nxt      = ST_ONE;
                    main_instr_nxt = instruc_in;
                    main_pc_nxt    = pc_adj;
                end
            end
            ST_ONE: begin
                if (acc && cons) begin
                    main_instr_nxt = instruc_in;
                    main_pc_nxt    = pc_adj;
                end else if (acc) begin
                    state_nxt      = ST_FULL;
                    skid_instr_nxt = instruc_in;
                    skid_pc_nxt    = pc_adj;
                end else if (cons) begin
                    state_nxt      = ST_EMPTY;
                    main_instr_nxt = NOP_INSTR;
                    main_pc_nxt    = '0;
                end
            end
            ST_FULL: begin
                if (cons) begin
                    state_nxt      = ST_ONE;
                    main_instr_nxt = skid_instr;
                    main_pc_nxt    = skid_pc;
                    skid_instr_nxt = NOP_INSTR;
                    skid_pc_nxt    = '0;
                end
            end
            default: begin
                // Unreachable encoding: recover to an empty latch.
                state_nxt      = ST_EMPTY;
                main_instr_nxt = NOP_INSTR;
                main_pc_nxt    = '0;
                skid_instr_nxt = NOP_INSTR;
                skid_pc_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_EMPTY;
            main_instr <= NOP_INSTR;
            main_pc    <= '0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
            flush_cnt  <= '0;
        end else if (flush) begin
            state      <= ST_EMPTY;
            main_instr <= NOP_INSTR;
            main_pc    <= '0;
            skid_instr <= NOP_INSTR;
            skid_pc    <= '0;
            if (state != ST_EMPTY && flush_cnt != {CNT_W{1'b1}})
                flush_cnt <= flush_cnt + CNT_W'(1);
        end else begin
            state      <= state_nxt;
            main_instr <= main_instr_nxt;
            main_pc    <= main_pc_nxt;
            skid_instr <= skid_instr_nxt;
            skid_pc    <= skid_pc_nxt;
        end
    end

endmodule

// File: tb/tb_if_id_skid_latch.sv
// Bench for if_id_skid_latch: directed scenarios then random traffic, scored against a
// queue model of the buffered beats; a second instance covers NOP encoding and a narrow counter.
module tb_if_id_skid_latch;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 11;

    logic               clock;
    logic               reset;
    logic               enable;
    logic               in_valid;
    logic [INSTR_W-1:0] instruc_in;
    logic [PC_W-1:0]    pc_plus_1_in;
    logic               branch_taken;
    logic               jump_sel;
    logic               out_ready;

    logic               in_ready0, out_valid0;
    logic [INSTR_W-1:0] instruc_out0;
    logic [PC_W-1:0]    pc_out0;
    logic [1:0]         occupancy0, fsm_state0;
    logic [15:0]        flush_cnt0;

    logic               in_ready1, out_valid1;
    logic [INSTR_W-1:0] instruc_out1;
    logic [PC_W-1:0]    pc_out1;
    logic [1:0]         occupancy1, fsm_state1;
    logic [1:0]         flush_cnt1;

    if_id_skid_latch u0 (
        .clock(clock), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready0),
        .instruc_in(instruc_in), .pc_plus_1_in(pc_plus_1_in),
        .branch_taken(branch_taken), .jump_sel(jump_sel),
        .out_valid(out_valid0), .out_ready(out_ready),
        .instruc_out(instruc_out0), .pc_out(pc_out0),
        .occupancy(occupancy0), .flush_cnt(flush_cnt0), .fsm_state(fsm_state0)
    );

    if_id_skid_latch #(.NOP_INSTR(32'h0000_0013), .CNT_W(2)) u1 (
        .clock(clock), .reset(reset), .enable(enable),
        .in_valid(in_valid), .in_ready(in_ready1),
        .instruc_in(instruc_in), .pc_plus_1_in(pc_plus_1_in),
        .branch_taken(branch_taken), .jump_sel(jump_sel),
        .out_valid(out_valid1), .out_ready(out_ready),
        .instruc_out(instruc_out1), .pc_out(pc_out1),
        .occupancy(occupancy1), .flush_cnt(flush_cnt1), .fsm_state(fsm_state1)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        reset = 1'b1; enable = 1'b1; in_valid = 1'b1; instruc_in = '0;
        pc_plus_1_in = '0; branch_taken = 1'b0; jump_sel = 1'b0; out_ready = 1'b0;
    end

    // scoreboard state: beats held by the latch, oldest first, as {instr, adjusted pc}
    logic [INSTR_W+PC_W-1:0] exp_q[$];
    int  exp_f0 = 0;
    int  exp_f1 = 0;
    bit  pending = 0;
    int  n_vec = 0;
    int  n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // driver: apply one cycle of inputs and record any beat the latch must accept
    task automatic step(input bit rst, input bit en, input bit iv, input logic [INSTR_W-1:0] ins,
                        input logic [PC_W-1:0] pc, input bit ordy, input bit br, input bit jmp);
        logic [PC_W-1:0] adj;
        @(posedge clock);
        #2;
        reset = rst; enable = en; in_valid = iv; instruc_in = ins;
        pc_plus_1_in = pc; out_ready = ordy; branch_taken = br; jump_sel = jmp;
        pending = 0;
        if (!rst && !br && !jmp && en && iv && exp_q.size() < 2) begin
            adj = pc - 11'd1;
            exp_q.push_back({ins, adj});
            pending = 1;
        end
    endtask

    // monitor: compare outputs mid-cycle, then apply the coming edge to the model
    always @(negedge clock) begin
        int occ_now;
        bit fl;
        logic [INSTR_W-1:0] e_ins;
        logic [PC_W-1:0]    e_pc;
        occ_now = exp_q.size() - (pending ? 1 : 0);
        fl = branch_taken | jump_sel;
        e_ins = '0;
        e_pc  = '0;
        if (occ_now != 0) {e_ins, e_pc} = exp_q[0];
        check("occupancy", 64'(occupancy0), 64'(occ_now));
        check("out_valid", 64'(out_valid0), 64'(occ_now != 0));
        check("in_ready", 64'(in_ready0), 64'((occ_now < 2) && !fl && !reset));
        check("instruc_out", 64'(instruc_out0), 64'(occ_now != 0 ? e_ins : 32'h0));
        check("pc_out", 64'(pc_out0), 64'(e_pc));
        check("flush_cnt", 64'(flush_cnt0), 64'(exp_f0));
        check("occupancy_nop13", 64'(occupancy1), 64'(occ_now));
        check("in_ready_nop13", 64'(in_ready1), 64'((occ_now < 2) && !fl && !reset));
        check("instruc_out_nop13", 64'(instruc_out1), 64'(occ_now != 0 ? e_ins : 32'h13));
        check("pc_out_nop13", 64'(pc_out1), 64'(e_pc));
        check("flush_cnt_w2", 64'(flush_cnt1), 64'(exp_f1));
        if (reset) begin
            exp_q.delete();
            exp_f0 = 0;
            exp_f1 = 0;
        end else if (fl) begin
            if (occ_now != 0) begin
                if (exp_f0 < 65535) exp_f0++;
                if (exp_f1 < 3) exp_f1++;
            end
            exp_q.delete();
        end else if (enable && out_ready && occ_now != 0) begin
            void'(exp_q.pop_front());
        end
    end

    initial begin
        // reset with in_valid high, then stream three beats
        step(1, 1, 1, 32'h99, 11'd3, 1, 0, 0);
        step(1, 1, 1, 32'h99, 11'd3, 1, 0, 0);
        step(0, 1, 1, 32'h11, 11'd5, 1, 0, 0);
        step(0, 1, 1, 32'h22, 11'd6, 1, 0, 0);
        step(0, 1, 1, 32'h33, 11'd7, 1, 0, 0);
        step(0, 1, 0, 32'h0,  11'd0, 1, 0, 0);
        step(0, 1, 0, 32'h0,  11'd0, 1, 0, 0);
        // skid fill with ID stalled, IF holding 0xA3, then drain
        step(0, 1, 1, 32'hA1, 11'd20, 0, 0, 0);
        step(0, 1, 1, 32'hA2, 11'd21, 0, 0, 0);
        step(0, 1, 1, 32'hA3, 11'd22, 0, 0, 0);
        step(0, 1, 1, 32'hA3, 11'd22, 0, 0, 0);
        step(0, 1, 1, 32'hA3, 11'd22, 1, 0, 0);
        step(0, 1, 1, 32'hA3, 11'd22, 1, 0, 0);
        step(0, 1, 0, 32'h0,  11'd0,  1, 0, 0);
        step(0, 1, 0, 32'h0,  11'd0,  1, 0, 0);
        step(0, 1, 0, 32'h0,  11'd0,  1, 0, 0);
        // flush while FULL with a beat offered
        step(0, 1, 1, 32'hB1, 11'd30, 0, 0, 0);
        step(0, 1, 1, 32'hB2, 11'd31, 0, 0, 0);
        step(0, 1, 1, 32'hB0, 11'd32, 1, 0, 1);
        step(0, 1, 0, 32'h0,  11'd0,  1, 0, 0);
        // flush when empty, enable gating, flush while disabled
        step(0, 1, 0, 32'h0,  11'd0,  1, 1, 0);
        step(0, 0, 1, 32'hC1, 11'd40, 1, 0, 0);
        step(0, 0, 1, 32'hC1, 11'd40, 1, 0, 0);
        step(0, 0, 1, 32'hC1, 11'd40, 1, 0, 0);
        step(0, 1, 1, 32'hC1, 11'd40, 0, 0, 0);
        step(0, 0, 0, 32'h0,  11'd0,  1, 0, 0);
        step(0, 0, 0, 32'h0,  11'd0,  1, 1, 0);
        step(0, 1, 0, 32'h0,  11'd0,  1, 0, 0);
        // PC wrap: pc_plus_1 of zero
        step(0, 1, 1, 32'hD0, 11'd0, 0, 0, 0);
        step(0, 1, 0, 32'h0,  11'd0, 1, 0, 0);
        step(0, 1, 0, 32'h0,  11'd0, 1, 0, 0);
        // five effective flushes saturate the narrow counter
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 1, 32'hE0 + 32'(i), 11'(50 + i), 0, 0, 0);
            step(0, 1, 0, 32'h0, 11'd0, 0, (i % 2) == 0, (i % 2) == 1);
        end
        step(0, 1, 0, 32'h0, 11'd0, 1, 0, 0);
        // reset while FULL
        step(0, 1, 1, 32'hF1, 11'd60, 0, 0, 0);
        step(0, 1, 1, 32'hF2, 11'd61, 0, 0, 0);
        step(1, 1, 1, 32'hF3, 11'd62, 0, 0, 0);
        step(0, 1, 0, 32'h0,  11'd0,  1, 0, 0);
        step(0, 1, 0, 32'h0,  11'd0,  1, 0, 0);
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(0, 199) == 0,
                 $urandom_range(0, 9) < 8,
                 $urandom_range(0, 9) < 7,
                 $urandom,
                 11'($urandom_range(0, 2047)),
                 $urandom_range(0, 9) < 6,
                 $urandom_range(0, 19) == 0,
                 $urandom_range(0, 29) == 0);
        end
        step(0, 1, 0, 32'h0, 11'd0, 1, 0, 0);
        step(0, 1, 0, 32'h0, 11'd0, 1, 0, 0);
        step(0, 1, 0, 32'h0, 11'd0, 1, 0, 0);
        @(negedge clock);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
